// File: rtl/axi_mem_pkg.sv
// Shared AXI burst/response encodings and the read-controller FSM state type.
package axi_mem_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;

  typedef enum logic {IDLE, BURST} state_t;

  // Only power-of-two burst lengths of 2..16 beats are legal wrap lengths.
  function automatic logic is_wrap_len(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_rom_rd_fifo.sv
// Three-entry synchronous FIFO that buffers ROM read data for the R channel.
module axi_rom_rd_fifo #(
  parameter int W = 133
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem [3];
  logic [1:0]   wr_ptr;
  logic [1:0]   rd_ptr;
  logic         do_push;
  logic         do_pop;

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign empty   = (count == 2'd0);
  assign do_push = push && (count != 2'd3);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage is cleared on reset so the R payload reads as zero while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) mem[i] <= '0;
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_next(rd_ptr);
      if (do_push && !do_pop)      count <= count + 2'd1;
      else if (!do_push && do_pop) count <= count - 2'd1;
    end
  end

endmodule

// File: rtl/axi_rom_rd_ctrl.sv
// AXI4 read-channel front-end for a 1-cycle-latency synchronous ROM:
// accepts AR bursts, issues one ROM read per beat and returns buffered R beats.
module axi_rom_rd_ctrl
  import axi_mem_pkg::*;
#(
  parameter int ADDR_WD = 32,
  parameter int DATA_WD = 128,
  parameter int ID_WD   = 4,
  parameter int ROM_AW  = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arvalid,
  output logic               arready,
  input  logic [ADDR_WD-1:0] araddr,
  input  logic [ID_WD-1:0]   arid,
  input  logic [7:0]         arlen,
  input  logic [1:0]         arburst,
  output logic               rvalid,
  input  logic               rready,
  output logic [DATA_WD-1:0] rdata,
  output logic [ID_WD-1:0]   rid,
  output logic [1:0]         rresp,
  output logic               rlast,
  output logic               rom_rd_en,
  output logic [ADDR_WD-1:0] rom_addr,
  input  logic [DATA_WD-1:0] rom_rdata
);

  localparam int BYTE_SHIFT = $clog2(DATA_WD / 8);
  localparam int FIFO_W     = DATA_WD + ID_WD + 1;

  state_t            state;
  logic [ID_WD-1:0]  id_q;
  logic [7:0]        len_q;
  logic [1:0]        burst_q;
  logic [7:0]        beat_q;
  logic [ROM_AW-1:0] idx_q;
  logic [ROM_AW-1:0] idx_inc;
  logic [ROM_AW-1:0] wrap_mask;
  logic [ROM_AW-1:0] next_idx;
  logic [ROM_AW-1:0] ar_idx;
  logic              infl_v;
  logic [ID_WD-1:0]  infl_id;
  logic              infl_last;
  logic [1:0]        fifo_count;
  logic              fifo_empty;
  logic [FIFO_W-1:0] fifo_dout;
  logic              unused_addr_bits;

  assign ar_idx           = araddr[BYTE_SHIFT +: ROM_AW];
  assign unused_addr_bits = ^{araddr[BYTE_SHIFT-1:0], araddr[ADDR_WD-1:BYTE_SHIFT+ROM_AW]};

  // Credit check uses only registered state, so rready never reaches rom_rd_en.
  assign rom_rd_en = (state == BURST) && (({1'b0, fifo_count} + {2'b00, infl_v}) < 3'd3);
  assign rom_addr  = {{(ADDR_WD-ROM_AW){1'b0}}, idx_q};

  assign idx_inc   = idx_q + {{(ROM_AW-1){1'b0}}, 1'b1};
  assign wrap_mask = {{(ROM_AW-4){1'b0}}, len_q[3:0]};

  always_comb begin
    next_idx = idx_inc;
    case (burst_q)
      BURST_FIXED: next_idx = idx_q;
      BURST_WRAP:  if (is_wrap_len(len_q)) next_idx = (idx_q & ~wrap_mask) | (idx_inc & wrap_mask);
      default:     next_idx = idx_inc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      arready <= 1'b0;
      id_q    <= '0;
      len_q   <= 8'd0;
      burst_q <= BURST_INCR;
      beat_q  <= 8'd0;
      idx_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arvalid && arready) begin
            id_q    <= arid;
            len_q   <= arlen;
            burst_q <= arburst;
            beat_q  <= 8'd0;
            idx_q   <= ar_idx;
            arready <= 1'b0;
            state   <= BURST;
          end else begin
            arready <= 1'b1;
          end
        end
        BURST: begin
          if (rom_rd_en) begin
            beat_q <= beat_q + 8'd1;
            idx_q  <= next_idx;
            if (beat_q == len_q) begin
              state   <= IDLE;
              arready <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag travels alongside the ROM's one-cycle read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl_v    <= 1'b0;
      infl_id   <= '0;
      infl_last <= 1'b0;
    end else begin
      infl_v <= rom_rd_en;
      if (rom_rd_en) begin
        infl_id   <= id_q;
        infl_last <= (beat_q == len_q);
      end
    end
  end

  axi_rom_rd_fifo #(.W(FIFO_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (infl_v),
    .din   ({rom_rdata, infl_id, infl_last}),
    .pop   (rvalid && rready),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rvalid = !fifo_empty;
  assign rdata  = fifo_dout[FIFO_W-1 -: DATA_WD];
  assign rid    = fifo_dout[ID_WD:1];
  assign rlast  = fifo_dout[0];
  assign rresp  = RESP_OKAY;

endmodule

// File: tb/tb_axi_rom_rd_ctrl.sv
// Scoreboard bench for axi_rom_rd_ctrl with a ROM model holding mem[i] = i.
module tb_axi_rom_rd_ctrl;

  localparam int ADDR_WD = 32;
  localparam int DATA_WD = 128;
  localparam int ID_WD   = 4;
  localparam int ROM_AW  = 11;

  logic               clk;
  logic               rst_n;
  logic               arvalid;
  logic               arready;
  logic [ADDR_WD-1:0] araddr;
  logic [ID_WD-1:0]   arid;
  logic [7:0]         arlen;
  logic [1:0]         arburst;
  logic               rvalid;
  logic               rready;
  logic [DATA_WD-1:0] rdata;
  logic [ID_WD-1:0]   rid;
  logic [1:0]         rresp;
  logic               rlast;
  logic               rom_rd_en;
  logic [ADDR_WD-1:0] rom_addr;
  logic [DATA_WD-1:0] rom_rdata;

  typedef struct {
    logic [DATA_WD-1:0] data;
    logic [ID_WD-1:0]   id;
    logic               last;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   rx_count    = 0;
  int   outstanding = 0;
  int   max_out     = 0;

  logic               hold_v;
  logic [DATA_WD-1:0] hold_data;
  logic [ID_WD-1:0]   hold_id;
  logic               hold_last;

  axi_rom_rd_ctrl #(
    .ADDR_WD(ADDR_WD), .DATA_WD(DATA_WD), .ID_WD(ID_WD), .ROM_AW(ROM_AW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid),
    .rresp(rresp), .rlast(rlast),
    .rom_rd_en(rom_rd_en), .rom_addr(rom_addr), .rom_rdata(rom_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: one-cycle latency, word i holds value i.
  always @(posedge clk) begin
    if (rom_rd_en) rom_rdata <= DATA_WD'(rom_addr[ROM_AW-1:0]);
  end

  task automatic checkOutput(input string name, input logic [DATA_WD-1:0] actual,
                             input logic [DATA_WD-1:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input logic [ID_WD-1:0] id, input logic [DATA_WD-1:0] data,
                         input logic last);
    exp_t e;
    e.data = data;
    e.id   = id;
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic [ID_WD-1:0] id, input logic [ADDR_WD-1:0] addr,
                               input logic [7:0] len, input logic [1:0] burst);
    int  waited;
    logic done;
    arvalid = 1'b1;
    arid    = id;
    araddr  = addr;
    arlen   = len;
    arburst = burst;
    waited  = 0;
    done    = 1'b0;
    while (!done && waited < 100) begin
      @(negedge clk);
      if (arready) done = 1'b1;
      @(posedge clk);
      #1;
      waited++;
    end
    arvalid = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL ar_handshake_timeout: got no arready, expected arready within 100 cycles");
    end
  endtask

  task automatic drainAll();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 300) begin
      @(posedge clk);
      #1;
      waited++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain_timeout: got %0d beats pending, expected 0", exp_q.size());
    end
  endtask

  // Monitor: pops the scoreboard on each R handshake and checks R stability under stall.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_v      = 1'b0;
      outstanding = 0;
    end else begin
      if (hold_v) begin
        checkOutput("stall_rvalid", DATA_WD'(rvalid), DATA_WD'(1));
        checkOutput("stall_rdata", rdata, hold_data);
        checkOutput("stall_rid", DATA_WD'(rid), DATA_WD'(hold_id));
        checkOutput("stall_rlast", DATA_WD'(rlast), DATA_WD'(hold_last));
      end
      if (rvalid && rready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_beat: got rdata %0h rid %0h, expected no beat", rdata, rid);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rdata", rdata, e.data);
          checkOutput("rid", DATA_WD'(rid), DATA_WD'(e.id));
          checkOutput("rlast", DATA_WD'(rlast), DATA_WD'(e.last));
          checkOutput("rresp", DATA_WD'(rresp), DATA_WD'(0));
          rx_count++;
        end
      end
      hold_v    = rvalid && !rready;
      hold_data = rdata;
      hold_id   = rid;
      hold_last = rlast;
      outstanding = outstanding + (rom_rd_en ? 1 : 0) - ((rvalid && rready) ? 1 : 0);
      if (outstanding > max_out) max_out = outstanding;
    end
  end

  initial begin
    int target;
    int waited;
    rst_n   = 1'b0;
    arvalid = 1'b0;
    araddr  = '0;
    arid    = '0;
    arlen   = 8'd0;
    arburst = 2'b01;
    rready  = 1'b1;
    rom_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_arready", DATA_WD'(arready), DATA_WD'(0));
    checkOutput("reset_rvalid", DATA_WD'(rvalid), DATA_WD'(0));
    checkOutput("reset_rom_rd_en", DATA_WD'(rom_rd_en), DATA_WD'(0));
    checkOutput("reset_rom_addr", DATA_WD'(rom_addr), DATA_WD'(0));
    checkOutput("reset_rdata", rdata, DATA_WD'(0));
    checkOutput("reset_rid_rlast", DATA_WD'({rid, rlast}), DATA_WD'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("arready_after_reset", DATA_WD'(arready), DATA_WD'(1));

    $display("[TB] single-beat INCR burst");
    pushExp(4'd3, 128'h4, 1'b1);
    applyStimulus(4'd3, 32'h40, 8'd0, 2'b01);
    checkOutput("t1_rom_rd_en_c1", DATA_WD'(rom_rd_en), DATA_WD'(1));
    checkOutput("t1_rom_addr_c1", DATA_WD'(rom_addr), DATA_WD'(4));
    @(posedge clk);
    #1;
    checkOutput("t1_rvalid_c2", DATA_WD'(rvalid), DATA_WD'(0));
    @(posedge clk);
    #1;
    checkOutput("t1_rvalid_c3", DATA_WD'(rvalid), DATA_WD'(1));
    drainAll();

    $display("[TB] INCR len7 crossing 0x80");
    for (int i = 0; i < 8; i++) pushExp(4'd9, DATA_WD'(8'h7F + i), (i == 7));
    applyStimulus(4'd9, 32'h7F0, 8'd7, 2'b01);
    drainAll();

    $display("[TB] WRAP len3 and FIXED len2");
    pushExp(4'd4, 128'h102, 1'b0);
    pushExp(4'd4, 128'h103, 1'b0);
    pushExp(4'd4, 128'h100, 1'b0);
    pushExp(4'd4, 128'h101, 1'b1);
    applyStimulus(4'd4, 32'h1020, 8'd3, 2'b10);
    pushExp(4'd8, 128'h5, 1'b0);
    pushExp(4'd8, 128'h5, 1'b0);
    pushExp(4'd8, 128'h5, 1'b1);
    applyStimulus(4'd8, 32'h50, 8'd2, 2'b00);
    drainAll();

    $display("[TB] INCR len15 under backpressure");
    @(posedge clk);
    #1;
    max_out = 0;
    rready  = 1'b0;
    for (int i = 0; i < 16; i++) pushExp(4'd5, DATA_WD'(8'h20 + i), (i == 15));
    applyStimulus(4'd5, 32'h200, 8'd15, 2'b01);
    repeat (10) @(posedge clk);
    #1;
    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      rready = ~rready;
      @(posedge clk);
      #1;
      waited++;
    end
    rready = 1'b1;
    drainAll();
    checkOutput("t4_max_outstanding", DATA_WD'(max_out), DATA_WD'(3));

    $display("[TB] back-to-back ARs with address alias");
    pushExp(4'd1, 128'h0, 1'b0);
    pushExp(4'd1, 128'h1, 1'b1);
    pushExp(4'd2, 128'h0, 1'b1);
    applyStimulus(4'd1, 32'h0, 8'd1, 2'b01);
    applyStimulus(4'd2, 32'h8000, 8'd0, 2'b01);
    drainAll();

    $display("[TB] reset in the middle of a burst");
    for (int i = 0; i < 8; i++) pushExp(4'd6, DATA_WD'(8'h30 + i), (i == 7));
    target = rx_count + 3;
    applyStimulus(4'd6, 32'h300, 8'd7, 2'b01);
    waited = 0;
    while (rx_count < target && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("t6_beats_before_reset", DATA_WD'(rx_count >= target), DATA_WD'(1));
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rvalid_in_reset", DATA_WD'(rvalid), DATA_WD'(0));
    checkOutput("t6_arready_in_reset", DATA_WD'(arready), DATA_WD'(0));
    checkOutput("t6_rom_rd_en_in_reset", DATA_WD'(rom_rd_en), DATA_WD'(0));
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t6_arready_after_release", DATA_WD'(arready), DATA_WD'(1));
    pushExp(4'd7, 128'h10, 1'b0);
    pushExp(4'd7, 128'h11, 1'b1);
    applyStimulus(4'd7, 32'h100, 8'd1, 2'b01);
    drainAll();
    repeat (10) @(posedge clk);
    #1;
    checkOutput("t6_no_stale_beat", DATA_WD'(rvalid), DATA_WD'(0));
    checkOutput("max_outstanding_bound", DATA_WD'(max_out <= 3), DATA_WD'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
